bp_fe_queue_roll_fifo: RTL
==========================

// Module: bp_fe_queue_roll_fifo
// PURPOSE
//  Fetch-queue storage between FE (producer) and the BE scheduler (consumer), with speculative dequeue.
//  Three pointers: write, speculative read and commit.
//  - Consumer yumi advances only the read pointer.
//  - deq_i (instruction committed) frees the entry.
//  - roll_i (cache miss replay) rewinds the read pointer to the oldest uncommitted entry.
//  - clr_i (FE redirect) discards all entries.
// PARAMETERS
//  els_p        8    queue depth in entries; power of two, >= 2
//  width_p      128  width of one FE queue packet (fetch or exception message), in bits
//  ptr_width_lp -    localparam, $clog2(els_p)+1 (index bits plus a wrap bit)
// PORTS
//  clk_i      in   1        clock; single clock domain
//  reset_n_i  in   1        asynchronous, active-low reset
//  data_i     in   width_p  FE packet to enqueue
//  v_i        in   1        enqueue valid; an enqueue happens when v_i & ready_o
//  ready_o    out  1        not full (uncommitted occupancy < els_p)
//  data_o     out  width_p  packet at the read pointer
//  v_o        out  1        read pointer != write pointer
//  yumi_i     in   1        consumer takes data_o; legal only when v_o
//  roll_i     in   1        rewind the read pointer to the commit pointer
//  deq_i      in   1        commit/free the oldest entry; legal only if commit ptr != read ptr
//  clr_i      in   1        flush: read and commit pointers := write pointer
//  empty_o    out  1        commit pointer == write pointer (no entries held)
// BEHAVIOUR
//  Reset (async assert, sync release): wptr = rptr = cptr = 0.
//   ready_o=1, v_o=0, empty_o=1. Storage is not reset; data_o is X whenever v_o=0.
//  Pointers are ptr_width_lp wide and increment modulo 2^ptr_width_lp.
//   Index = low $clog2(els_p) bits. The MSB is the wrap bit.
//  full  = (wptr.idx==cptr.idx) & (wptr.msb!=cptr.msb)  -> ready_o=~full
//  v_o   = (rptr != wptr)
//  Write: the entry is written at wptr on clk edge; v_o rises the next cycle (no bypass).
//   Write latency is 1 cycle.
//  Read: data_o = mem[rptr.idx], combinational from the flop array.
//  Per-cycle priority, evaluated on the registered pointers:
//   1. clr_i: rptr,cptr <= wptr; any enqueue in this cycle is dropped; yumi, roll, deq ignored.
//   2. deq_i: cptr <= cptr+1.
//   3. roll_i: rptr <= the cptr value after step 2. A yumi in the same cycle is ignored.
//   4. else yumi_i: rptr <= rptr+1.
//   5. Enqueue is independent of 2-4: wptr <= wptr+1 when v_i & ready_o & ~clr_i.
//  Full: ready_o is computed from cptr, so uncommitted entries are never overwritten.
//   A deq in the same cycle does NOT raise ready_o combinationally.
//  Empty: yumi_i with v_o=0, or deq_i with cptr==rptr, is illegal; assert in simulation.
//   In RTL the pointers hold.
//  Wrap-around: all comparisons use the full pointers including the wrap bit.
//   rptr is always in [cptr, wptr] modulo wrap.
//  Reset mid-operation: all state clears immediately (async); in-flight entries are lost.
// STRUCTURE
//  bp_be_pkg: no new types. The width_p packet is bp_fe_queue_s from the existing
//   FE/BE interface macros and is treated here as opaque bits.
//  One sub-module: bp_fe_queue_ptr.
//   Ports: clk_i, reset_n_i, inc_i, set_i, set_val_i, ptr_o.
//   Async-reset wrapping counter; instanced three times (w, r, c).
//  Storage: els_p x width_p flop array, write-enabled per entry; no SRAM.
// TESTING
//  1 Enqueue A,B,C (yumi low) -> v_o=1 from cycle 1, data_o=A, empty_o=0.
//    Three yumis then read A,B,C; v_o=0 after the third.
//  2 Fill 8 with no deq -> ready_o=0 on 8th+1 cycle; a 9th v_i is not accepted.
//    Then one deq -> ready_o=1 the following cycle.
//  3 Enqueue A..D, yumi x3, deq x1, roll -> data_o=B next cycle.
//    Replay yumis return B,C,D.
//  4 roll_i, deq_i and yumi_i in the same cycle, with cptr at A and rptr at C
//    -> rptr=cptr=B; the yumi is dropped.
//  5 clr_i with 5 entries and a concurrent v_i -> v_o=0, empty_o=1, ready_o=1.
//    The concurrent packet does not appear.
//  6 Run 3*els_p enqueue/yumi/deq cycles to exercise wrap; assert reset_n_i mid-stream
//    -> outputs go to reset values asynchronously; the queue is empty after release.

Source files
------------

// File: rtl/bp_fe_queue_roll_fifo_pkg.sv
// Shared types for the FE fetch queue: read-pointer update selection.
// The queued packet itself is opaque bits; no packet types live here.
package bp_fe_queue_roll_fifo_pkg;

  typedef enum logic [1:0] {
    rd_hold   = 2'd0,
    rd_adv    = 2'd1,
    rd_rewind = 2'd2,
    rd_flush  = 2'd3
  } rd_op_e;

  // Flush beats rewind beats a consumer take; a take while rewinding is dropped.
  function automatic rd_op_e rd_op_sel(input logic clr, input logic roll, input logic yumi_ok);
    rd_op_e op;
    op = rd_hold;
    if (clr)          op = rd_flush;
    else if (roll)    op = rd_rewind;
    else if (yumi_ok) op = rd_adv;
    return op;
  endfunction

endpackage

// File: rtl/bp_fe_queue_roll_fifo_if.sv
// Producer/consumer/control bundle for the FE fetch queue.
// Handshake: enqueue fires when v_i & ready_o; a take fires when yumi_i (only legal with v_o).
interface bp_fe_queue_roll_fifo_if #(parameter int width_p = 128) ();
  logic [width_p-1:0] data_i;
  logic               v_i;
  logic               ready_o;
  logic [width_p-1:0] data_o;
  logic               v_o;
  logic               yumi_i;
  logic               roll_i;
  logic               deq_i;
  logic               clr_i;
  logic               empty_o;

  modport master (
    output data_i, v_i, yumi_i, roll_i, deq_i, clr_i,
    input  ready_o, data_o, v_o, empty_o
  );

  modport slave (
    input  data_i, v_i, yumi_i, roll_i, deq_i, clr_i,
    output ready_o, data_o, v_o, empty_o
  );
endinterface

// File: rtl/bp_fe_queue_ptr.sv
// Wrapping pointer with async clear; a load takes priority over an increment.
module bp_fe_queue_ptr #(
  parameter int ptr_width_p = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   inc_i,
  input  logic                   set_i,
  input  logic [ptr_width_p-1:0] set_val_i,
  output logic [ptr_width_p-1:0] ptr_o
);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)  ptr_o <= '0;
    else if (set_i)  ptr_o <= set_val_i;
    else if (inc_i)  ptr_o <= ptr_o + 1'b1;
  end

endmodule

// File: rtl/bp_fe_queue_roll_fifo.sv
// FE fetch queue with speculative read: write, speculative read and commit pointers.
// Rolling rewinds the read pointer to the oldest uncommitted entry for replay.
module bp_fe_queue_roll_fifo
  import bp_fe_queue_roll_fifo_pkg::*;
#(
  parameter int els_p   = 8,
  parameter int width_p = 128
) (
  input logic clk_i,
  input logic reset_n_i,
  bp_fe_queue_roll_fifo_if.slave q
);

  localparam int idx_width_lp = $clog2(els_p);
  localparam int ptr_width_lp = idx_width_lp + 1;

  logic [ptr_width_lp-1:0] wptr, rptr, cptr, cptr_after;
  logic [ptr_width_lp-1:0] r_set_val;
  logic                    r_set, r_inc;
  logic                    full, enq, yumi_ok, deq_ok;
  rd_op_e                  rd_op;

  logic [width_p-1:0] mem [els_p];

  // Full is judged against the commit pointer so unretired entries stay intact.
  assign full = (wptr[idx_width_lp-1:0] == cptr[idx_width_lp-1:0])
              & (wptr[ptr_width_lp-1] != cptr[ptr_width_lp-1]);

  assign q.ready_o = ~full;
  assign q.v_o     = (rptr != wptr);
  assign q.empty_o = (cptr == wptr);
  assign q.data_o  = mem[rptr[idx_width_lp-1:0]];

  assign enq     = q.v_i & ~full & ~q.clr_i;
  assign yumi_ok = q.yumi_i & q.v_o;
  assign deq_ok  = q.deq_i & (cptr != rptr) & ~q.clr_i;

  // A roll in the same cycle as a commit must land on the post-commit entry.
  assign cptr_after = cptr + {{(ptr_width_lp-1){1'b0}}, deq_ok};
  assign rd_op      = rd_op_sel(q.clr_i, q.roll_i, yumi_ok);

  always_comb begin
    r_set     = 1'b0;
    r_inc     = 1'b0;
    r_set_val = wptr;
    case (rd_op)
      rd_flush:  r_set = 1'b1;
      rd_rewind: begin
        r_set     = 1'b1;
        r_set_val = cptr_after;
      end
      rd_adv:    r_inc = 1'b1;
      default:   ;
    endcase
  end

  bp_fe_queue_ptr #(.ptr_width_p(ptr_width_lp)) w_ptr (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .inc_i(enq), .set_i(1'b0), .set_val_i('0), .ptr_o(wptr)
  );

  bp_fe_queue_ptr #(.ptr_width_p(ptr_width_lp)) r_ptr (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .inc_i(r_inc), .set_i(r_set), .set_val_i(r_set_val), .ptr_o(rptr)
  );

  bp_fe_queue_ptr #(.ptr_width_p(ptr_width_lp)) c_ptr (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .inc_i(deq_ok), .set_i(q.clr_i), .set_val_i(wptr), .ptr_o(cptr)
  );

  // Storage is deliberately unreset; contents are only visible while v_o is high.
  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr[idx_width_lp-1:0]] <= q.data_i;
  end

  a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    q.yumi_i |-> q.v_o);
  a_deq_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (q.deq_i && !q.clr_i) |-> (cptr != rptr));

endmodule
